// File: rtl/score_readback_bcd.sv
// score_readback_bcd: scans stored reaction times from the register file,
// reduces them to one statistic (best, average, last, run count) and
// converts the result to four BCD digits for the seven-segment decoders.
module score_readback_bcd #(
   parameter int SCORE_W = 13,
   parameter int ADDR_W  = 3
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [1:0]         Select,
   input  logic [SCORE_W-1:0] RunCount,
   output logic [ADDR_W-1:0]  ReadQ,
   input  logic [SCORE_W-1:0] DataQ,
   output logic               Busy,
   output logic               Done,
   output logic [3:0]         Digit0,
   output logic [3:0]         Digit1,
   output logic [3:0]         Digit2,
   output logic [3:0]         Digit3
);

   localparam int MAX_SLOT = (1 << ADDR_W) - 1;
   localparam int SUM_W    = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SCAN = 3'd1,
      DIV  = 3'd2,
      BCD  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t stateR, stateNextS;

   logic [1:0]         selR;
   logic [ADDR_W-1:0]  nR;
   logic [SUM_W-1:0]   sumR;      // running sum in SCAN, quotient shift register in DIV
   logic [SCORE_W-1:0] bestR;
   logic [SCORE_W-1:0] lastR;
   logic [ADDR_W-1:0]  remR;
   logic [3:0]         cntR;
   logic [SCORE_W-1:0] binR;
   logic [15:0]        bcdR;

   logic [ADDR_W-1:0]  nStartS;
   logic               scanLastS;
   logic [ADDR_W:0]    divTrialS;
   logic               divFitS;
   logic [ADDR_W:0]    divDiffS;
   logic [ADDR_W-1:0]  divRemNextS;
   logic [SUM_W-1:0]   quotNextS;
   logic [SCORE_W-1:0] avgS;
   logic [SCORE_W-1:0] valueS;
   logic [15:0]        bcdNextS;

   // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [15:0] dabbleStep(input logic [15:0] bcdIn, input logic bitIn);
      logic [15:0] adj;
      adj = bcdIn;
      for (int k = 0; k < 4; k++) begin
         if (adj[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
         end else begin
            adj[4*k +: 4] = adj[4*k +: 4];
         end
      end
      return {adj[14:0], bitIn};
   endfunction

   // Datapath helpers: slot count clamp, scan end, one restoring-division step, result mux.
   always_comb begin
      nStartS     = RunCount[ADDR_W-1:0];
      scanLastS   = 1'b0;
      divTrialS   = {remR, sumR[SUM_W-1]};
      divFitS     = 1'b0;
      divDiffS    = divTrialS;
      divRemNextS = divTrialS[ADDR_W-1:0];
      quotNextS   = {sumR[SUM_W-2:0], 1'b0};
      avgS        = {SCORE_W{1'b0}};
      valueS      = {SCORE_W{1'b0}};
      bcdNextS    = dabbleStep(bcdR, binR[SCORE_W-1]);

      if (RunCount > SCORE_W'(MAX_SLOT)) begin
         nStartS = ADDR_W'(MAX_SLOT);
      end else begin
         nStartS = RunCount[ADDR_W-1:0];
      end

      if ((nR == {ADDR_W{1'b0}}) || (ReadQ == nR)) begin
         scanLastS = 1'b1;
      end else begin
         scanLastS = 1'b0;
      end

      // Remainder stays below N, so it always fits back into ADDR_W bits.
      if (divTrialS >= {1'b0, nR}) begin
         divFitS     = 1'b1;
         divDiffS    = divTrialS - {1'b0, nR};
         divRemNextS = divDiffS[ADDR_W-1:0];
      end else begin
         divFitS     = 1'b0;
         divDiffS    = divTrialS;
         divRemNextS = divTrialS[ADDR_W-1:0];
      end
      quotNextS = {sumR[SUM_W-2:0], divFitS};

      // Division by zero would yield all ones; an empty table averages to 0.
      if (nR == {ADDR_W{1'b0}}) begin
         avgS = {SCORE_W{1'b0}};
      end else begin
         avgS = quotNextS[SCORE_W-1:0];
      end

      case (selR)
         2'd0:    valueS = bestR;
         2'd1:    valueS = avgS;
         2'd2:    valueS = lastR;
         2'd3:    valueS = {{(SCORE_W-ADDR_W){1'b0}}, nR};
         default: valueS = {SCORE_W{1'b0}};
      endcase
   end

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stateR <= IDLE;
      end else begin
         stateR <= stateNextS;
      end
   end

   // Next-state logic.
   always_comb begin
      stateNextS = stateR;
      case (stateR)
         IDLE: begin
            if (Start) begin
               stateNextS = SCAN;
            end else begin
               stateNextS = IDLE;
            end
         end
         SCAN: begin
            if (scanLastS) begin
               stateNextS = DIV;
            end else begin
               stateNextS = SCAN;
            end
         end
         DIV: begin
            if (cntR == 4'd15) begin
               stateNextS = BCD;
            end else begin
               stateNextS = DIV;
            end
         end
         BCD: begin
            if (cntR == 4'(SCORE_W - 1)) begin
               stateNextS = DONE;
            end else begin
               stateNextS = BCD;
            end
         end
         DONE:    stateNextS = IDLE;
         default: stateNextS = IDLE;
      endcase
   end

   // Datapath and registered outputs, advanced in step with the state register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         selR   <= 2'd0;
         nR     <= {ADDR_W{1'b0}};
         sumR   <= {SUM_W{1'b0}};
         bestR  <= {SCORE_W{1'b1}};
         lastR  <= {SCORE_W{1'b0}};
         remR   <= {ADDR_W{1'b0}};
         cntR   <= 4'd0;
         binR   <= {SCORE_W{1'b0}};
         bcdR   <= 16'd0;
         ReadQ  <= {ADDR_W{1'b0}};
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Digit0 <= 4'd0;
         Digit1 <= 4'd0;
         Digit2 <= 4'd0;
         Digit3 <= 4'd0;
      end else begin
         case (stateR)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  selR  <= Select;
                  nR    <= nStartS;
                  sumR  <= {SUM_W{1'b0}};
                  bestR <= {SCORE_W{1'b1}};
                  lastR <= {SCORE_W{1'b0}};
                  cntR  <= 4'd0;
                  Busy  <= 1'b1;
                  if (nStartS == {ADDR_W{1'b0}}) begin
                     ReadQ <= {ADDR_W{1'b0}};
                  end else begin
                     ReadQ <= ADDR_W'(1);
                  end
               end
            end
            SCAN: begin
               if (nR == {ADDR_W{1'b0}}) begin
                  bestR <= {SCORE_W{1'b0}};
                  lastR <= {SCORE_W{1'b0}};
               end else begin
                  sumR  <= sumR + {{(SUM_W-SCORE_W){1'b0}}, DataQ};
                  lastR <= DataQ;
                  if (DataQ < bestR) begin
                     bestR <= DataQ;
                  end
               end
               if (scanLastS) begin
                  ReadQ <= {ADDR_W{1'b0}};
                  remR  <= {ADDR_W{1'b0}};
                  cntR  <= 4'd0;
               end else begin
                  ReadQ <= ReadQ + ADDR_W'(1);
               end
            end
            DIV: begin
               sumR <= quotNextS;
               remR <= divRemNextS;
               cntR <= cntR + 4'd1;
               if (cntR == 4'd15) begin
                  // Final quotient bit is produced on this edge, so load the BCD input from it directly.
                  binR <= valueS;
                  bcdR <= 16'd0;
                  cntR <= 4'd0;
               end
            end
            BCD: begin
               bcdR <= bcdNextS;
               binR <= {binR[SCORE_W-2:0], 1'b0};
               cntR <= cntR + 4'd1;
               if (cntR == 4'(SCORE_W - 1)) begin
                  Digit0 <= bcdNextS[3:0];
                  Digit1 <= bcdNextS[7:4];
                  Digit2 <= bcdNextS[11:8];
                  Digit3 <= bcdNextS[15:12];
                  Busy   <= 1'b0;
                  Done   <= 1'b1;
               end
            end
            DONE: begin
               Done <= 1'b0;
               Busy <= 1'b0;
            end
            default: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               ReadQ <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_readback_bcd.sv
// Self-checking bench for score_readback_bcd: directed cases plus randomized
// readbacks compared against an arithmetic reference model.
module tb_score_readback_bcd;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [1:0]  Select;
   logic [12:0] RunCount;
   logic [2:0]  ReadQ;
   logic [12:0] DataQ;
   logic        Busy;
   logic        Done;
   logic [3:0]  Digit0, Digit1, Digit2, Digit3;

   logic [12:0] mem [0:7];
   int          checks = 0;
   int          failures = 0;

   assign DataQ = mem[ReadQ];

   always #5 Clock = ~Clock;

   score_readback_bcd #(.SCORE_W(13), .ADDR_W(3)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Select(Select),
      .RunCount(RunCount), .ReadQ(ReadQ), .DataQ(DataQ), .Busy(Busy),
      .Done(Done), .Digit0(Digit0), .Digit1(Digit1), .Digit2(Digit2),
      .Digit3(Digit3)
   );

   task automatic checkVal(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: statistic from the table contents using plain arithmetic.
   function automatic int modelValue(input int rc, input int sel);
      int n, sum, best, last;
      n = (rc > 7) ? 7 : rc;
      sum = 0; best = 8191; last = 0;
      for (int i = 1; i <= n; i++) begin
         sum += mem[i];
         if (mem[i] < best) best = mem[i];
         last = mem[i];
      end
      if (n == 0) begin
         best = 0; last = 0;
      end
      case (sel)
         0: return best;
         1: return (n == 0) ? 0 : sum / n;
         2: return last;
         default: return n;
      endcase
   endfunction

   task automatic checkDigits(input string tag, input int value);
      checkVal({tag, ".d0"}, Digit0, value % 10);
      checkVal({tag, ".d1"}, Digit1, (value / 10) % 10);
      checkVal({tag, ".d2"}, Digit2, (value / 100) % 10);
      checkVal({tag, ".d3"}, Digit3, (value / 1000) % 10);
   endtask

   // One complete readback; pulseAt >= 0 re-pulses Start during that cycle of the operation.
   task automatic runOp(input string tag, input int rc, input int sel, input int pulseAt);
      int n, s, expVal, doneAt, doneCnt, qErr, busyErr, maxQ, expQ;
      n = (rc > 7) ? 7 : rc;
      s = (n == 0) ? 1 : n;
      expVal = modelValue(rc, sel);
      doneAt = -1; doneCnt = 0; qErr = 0; busyErr = 0; maxQ = 0;
      @(negedge Clock);
      RunCount = 13'(rc);
      mem[0] = 13'(rc);
      Select = 2'(sel);
      Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      RunCount = 13'($urandom);
      Select = 2'($urandom);
      for (int c = 0; c < s + 34; c++) begin
         expQ = (c < s && n != 0) ? c + 1 : 0;
         if (ReadQ != 3'(expQ)) qErr++;
         if (int'(ReadQ) > maxQ) maxQ = ReadQ;
         if (Busy != (c < s + 29)) busyErr++;
         if (Done) begin
            doneCnt++;
            if (doneAt < 0) doneAt = c;
         end
         @(negedge Clock);
         Start = (c == pulseAt) ? 1'b1 : 1'b0;
         @(posedge Clock); #1;
      end
      Start = 1'b0;
      checkVal({tag, ".doneAt"}, doneAt, s + 29);
      checkVal({tag, ".doneCnt"}, doneCnt, 1);
      checkVal({tag, ".readQseq"}, qErr, 0);
      checkVal({tag, ".busy"}, busyErr, 0);
      checkVal({tag, ".maxQ"}, maxQ, n);
      checkDigits(tag, expVal);
   endtask

   initial begin
      int firstDone, secondDone, doneSeen;
      Reset = 1'b1; Start = 1'b0; Select = 2'd0; RunCount = 13'd0;
      for (int i = 0; i < 8; i++) mem[i] = 13'd0;
      repeat (2) @(posedge Clock);
      #1;
      checkVal("reset.busy", Busy, 0);
      checkVal("reset.done", Done, 0);
      checkVal("reset.readQ", ReadQ, 0);
      checkDigits("reset", 0);
      @(negedge Clock);
      Reset = 1'b0;

      // Best / average / last over three slots
      mem[1] = 13'd250; mem[2] = 13'd180; mem[3] = 13'd420;
      runOp("best", 3, 0, -1);
      runOp("avg", 3, 1, -1);
      runOp("last", 3, 2, -1);
      runOp("busyPulse", 3, 1, 5);

      // Full table, run count above the slot limit
      for (int i = 1; i < 8; i++) mem[i] = 13'd8191;
      runOp("fullAvg", 12, 1, -1);
      runOp("fullCnt", 12, 3, -1);
      runOp("fullBest", 12, 0, -1);

      // Empty table
      runOp("emptyBest", 0, 0, -1);
      runOp("emptyAvg", 0, 1, -1);

      // Randomized readbacks
      for (int t = 0; t < 24; t++) begin
         for (int i = 1; i < 8; i++) mem[i] = 13'($urandom_range(0, 8191));
         runOp($sformatf("rand%0d", t),
               (t % 3 == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 9)),
               int'($urandom_range(0, 3)), -1);
      end

      // Reset during an active scan aborts and clears the digits
      mem[1] = 13'd250; mem[2] = 13'd180; mem[3] = 13'd420;
      @(negedge Clock);
      RunCount = 13'd7; Select = 2'd2; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock); #1;
      checkVal("midReset.busy", Busy, 0);
      checkVal("midReset.done", Done, 0);
      checkVal("midReset.readQ", ReadQ, 0);
      checkDigits("midReset", 0);
      doneSeen = 0;
      repeat (40) begin
         @(posedge Clock); #1;
         if (Done) doneSeen++;
      end
      checkVal("midReset.noDone", doneSeen, 0);

      // Start held high retriggers after every DONE
      @(negedge Clock);
      RunCount = 13'd3; Select = 2'd0; Start = 1'b1;
      firstDone = -1; secondDone = -1;
      for (int c = 0; c < 120; c++) begin
         @(posedge Clock); #1;
         if (Done) begin
            if (firstDone < 0) firstDone = c;
            else if (secondDone < 0) secondDone = c;
         end
      end
      checkVal("holdStart.seen", (firstDone >= 0 && secondDone >= 0) ? 1 : 0, 1);
      checkVal("holdStart.period", secondDone - firstDone, 34);
      checkDigits("holdStart", 180);
      @(negedge Clock);
      Start = 1'b0;
      repeat (50) @(posedge Clock);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
